la_aoi311_pipe: RTL and testbench
=================================

Name: la_aoi311_pipe

Overview:
- Parametrised, pipelined successor to the single-bit aoi311 cell.
- Computes a W-bit-wide And-Or(-Invert) function with an NA-input AND term and NO single-input OR terms.
- Result passes through a STAGES-deep valid/ready pipeline with a runtime invert-mode select.
- Used where wide AOI reductions sit on timing-critical, flow-controlled datapaths.

Parameters:
- W, 1, bit width of every operand lane and of z.
- NA, 3, number of AND-term operands (>=1).
- NO, 2, number of single OR-term operands (>=0; 0 means no OR terms).
- STAGES, 1, pipeline register stages (>=1).
- PROP, "DEFAULT", implementation property string, passed through, no functional effect.

Ports:
- clk  input  1  clock, all state on rising edge.
- nreset  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  pipeline can accept a beat this cycle.
- a  input  NA*W  AND operands; lane k = a[k*W +: W].
- b  input  max(NO,1)*W  OR operands; lane j = b[j*W +: W]; ignored when NO=0.
- mode  input  1  0 = AOI (inverted), 1 = AO (non-inverted); sampled with the beat.
- out_valid  output  1  z holds a valid result.
- out_ready  input  1  downstream accepts z this cycle.
- z  output  W  result.

Behaviour:
- Function, per bit i:
  - f = (AND over k of a_k[i]) | (OR over j of b_j[i]).
  - z[i] = mode ? f : ~f.
  - With NA=3, NO=2, W=1, mode=0 this matches aoi311 exactly.
- Evaluation: f and the mode select are computed combinationally at the input and captured into stage 0. Later stages are pure register slices, each holding data[W] and a full bit.
- Accept: a beat is accepted when in_valid & in_ready.
- Stage ready:
  - ready[s] = ~full[s] | ready[s+1].
  - ready[STAGES] = out_ready.
  - in_ready = ready[0].
  - This is a combinational ready chain, giving full throughput: 1 beat/cycle with no bubbles.
- Stage advance: stage s loads from stage s-1 (or from the input) when ready[s].
  - full[s] is set if the upstream source was valid, otherwise cleared.
  - If ~ready[s], data and full hold.
- Outputs: out_valid = full[STAGES-1]; z = data[STAGES-1].
- Latency: a beat accepted at edge n appears on out_valid/z after edge n+STAGES-1, i.e. STAGES cycles after presentation, with no backpressure.
- Backpressure: while out_valid & ~out_ready, z and out_valid are held stable.
  - Bubbles upstream still compress.
  - in_ready falls only when all STAGES slots are full.
  - Capacity is exactly STAGES beats.
- Simultaneous events:
  - Full pipeline with out_ready=1: in_ready=1, and accept plus drain occur in the same cycle.
  - Ordering is strictly FIFO; no beat is dropped or duplicated.
- Reset:
  - nreset low immediately (asynchronously) clears all full bits and data registers, so out_valid=0 and z=0 on every stage.
  - in_ready=1 whenever the pipeline is empty.
  - Reset mid-operation discards all in-flight beats.
  - Release of reset must be synchronised externally; no beat is accepted during reset.
- Inputs a, b, mode, in_valid are don't-care when not being accepted.
- No X propagation from unused b lanes when NO=0.

Test Plan:
Configuration W=4, NA=3, NO=2, STAGES=2 unless noted.
1. Reset: assert nreset=0 mid-stream with 2 beats in flight -> out_valid=0 and z=4'h0 asynchronously; after release, in_ready=1 and no stale beat ever appears.
2. Single AOI beat: a lanes {F,F,3}, b lanes {0,0}, mode=0, out_ready=1 -> out_valid=1 exactly 2 cycles later, z=4'hC, then out_valid=0.
3. AO mode: same operands with mode=1 -> z=4'h3; with b lane0=4'h8 and mode=0 -> z=4'h4.
4. Backpressure: out_ready=0, drive 3 consecutive beats -> 2 accepted, in_ready=0 on the third, z stable. Raise out_ready -> beats emerge in order, one per cycle, and the third is accepted.
5. Streaming: 16 random beats with in_valid=1 and out_ready=1 continuously -> 16 results, one per cycle, matching the reference model, with no bubbles after the first 2 cycles.
6. Parameter sweep: W=1, NA=3, NO=2, STAGES=1 exhaustive over 32 input combinations, mode=0 -> z equals ~((a0&a1&a2)|b0|c0) for each. NO=0 and STAGES=4 random runs -> ordering and latency 4 correct.

Source files
------------

// File: rtl/la_aoi311_pipe.sv
// Pipelined W-bit And-Or(-Invert) reduction: NA-input AND term OR'ed with NO
// single-input terms, runtime invert select, STAGES-deep valid/ready slice chain.
module la_aoi311_pipe #(
  parameter int W      = 1,
  parameter int NA     = 3,
  parameter int NO     = 2,
  parameter int STAGES = 1,
  parameter     PROP   = "DEFAULT"
) (
  input  logic                                 clk,
  input  logic                                 nreset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NA*W-1:0]                      a,
  input  logic [((NO > 0) ? NO : 1)*W-1:0]     b,
  input  logic                                 mode,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [W-1:0]                         z
);

  // PROP only tags the implementation; it has no functional effect.
  localparam int PROP_UNUSED = $bits(PROP);

  logic [W-1:0]    w_and;
  logic [W-1:0]    w_or;
  logic [W-1:0]    w_f;
  logic [W-1:0]    w_z;
  logic [STAGES:0] w_ready;
  logic            w_b_unused;

  logic [W-1:0]    r_data [STAGES];
  logic            r_full [STAGES];

  // With NO=0 the b port is dead; its lanes never reach the OR term.
  assign w_b_unused = ^b;

  always_comb begin
    w_and = '1;
    for (int k = 0; k < NA; k++) begin
      w_and = w_and & a[k*W +: W];
    end
    w_or = '0;
    for (int j = 0; j < NO; j++) begin
      w_or = w_or | b[j*W +: W];
    end
  end

  assign w_f = w_and | w_or;
  assign w_z = mode ? w_f : ~w_f;

  // Ready ripples from the output back to the input in one combinational pass,
  // so a full pipeline can accept and drain in the same cycle.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      w_ready[s] = ~r_full[s] | w_ready[s+1];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int s = 0; s < STAGES; s++) begin
        r_full[s] <= 1'b0;
        r_data[s] <= '0;
      end
    end else begin
      if (w_ready[0]) begin
        r_full[0] <= in_valid;
        r_data[0] <= w_z;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (w_ready[s]) begin
          r_full[s] <= r_full[s-1];
          r_data[s] <= r_data[s-1];
        end
      end
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_full[STAGES-1];
  assign z         = r_data[STAGES-1];

endmodule

// File: tb/tb_la_aoi311_pipe.sv
// Directed and scoreboarded checks of la_aoi311_pipe in three configurations:
// W=4/NA=3/NO=2/STAGES=2, W=1/STAGES=1 exhaustive, and W=4/NO=0/STAGES=4.
module tb_la_aoi311_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset;
  int   total = 0;
  int   bad   = 0;

  // main configuration
  logic        m_in_valid, m_in_ready, m_mode, m_out_valid, m_out_ready;
  logic [11:0] m_a;
  logic [7:0]  m_b;
  logic [3:0]  m_z;

  // single-bit sweep configuration
  logic        s_in_valid, s_in_ready, s_mode, s_out_valid, s_out_ready;
  logic [2:0]  s_a;
  logic [1:0]  s_b;
  logic [0:0]  s_z;

  // no-OR-term, deep configuration
  logic        n_in_valid, n_in_ready, n_mode, n_out_valid, n_out_ready;
  logic [11:0] n_a;
  logic [3:0]  n_b;
  logic [3:0]  n_z;

  la_aoi311_pipe #(.W(4), .NA(3), .NO(2), .STAGES(2), .PROP("DEFAULT")) u_main (
    .clk(clk), .nreset(nreset), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .mode(m_mode), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .z(m_z)
  );

  la_aoi311_pipe #(.W(1), .NA(3), .NO(2), .STAGES(1), .PROP("DEFAULT")) u_sweep (
    .clk(clk), .nreset(nreset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .mode(s_mode), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .z(s_z)
  );

  la_aoi311_pipe #(.W(4), .NA(3), .NO(0), .STAGES(4), .PROP("DEFAULT")) u_noor (
    .clk(clk), .nreset(nreset), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .mode(n_mode), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .z(n_z)
  );

  typedef struct {
    logic [11:0] a;
    logic [7:0]  b;
    logic        mode;
    logic [3:0]  exp_z;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", name, act, $time);
    end
  endtask

  function automatic logic [3:0] ref_main(input logic [11:0] a, input logic [7:0] b,
                                          input logic mode);
    logic [3:0] f;
    f = (a[3:0] & a[7:4] & a[11:8]) | b[3:0] | b[7:4];
    return mode ? f : ~f;
  endfunction

  function automatic logic [3:0] ref_noor(input logic [11:0] a, input logic mode);
    logic [3:0] f;
    f = a[3:0] & a[7:4] & a[11:8];
    return mode ? f : ~f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] q [$];
    logic [3:0] exp4;
    logic       exp_prev;
    int         got, first_c, last_c, sent, rcv;

    vecs[0] = '{a: 12'h3FF, b: 8'h00, mode: 1'b0, exp_z: 4'hC};
    vecs[1] = '{a: 12'h3FF, b: 8'h00, mode: 1'b1, exp_z: 4'h3};
    vecs[2] = '{a: 12'h3FF, b: 8'h08, mode: 1'b0, exp_z: 4'h4};
    vecs[3] = '{a: 12'hFFF, b: 8'h00, mode: 1'b0, exp_z: 4'h0};
    vecs[4] = '{a: 12'h000, b: 8'h50, mode: 1'b0, exp_z: 4'hA};
    vecs[5] = '{a: 12'h0F0, b: 8'h21, mode: 1'b1, exp_z: 4'h3};

    nreset = 1'b0;
    m_in_valid = 0; m_out_ready = 1; m_a = '0; m_b = '0; m_mode = 0;
    s_in_valid = 0; s_out_ready = 1; s_a = '0; s_b = '0; s_mode = 0;
    n_in_valid = 0; n_out_ready = 1; n_a = '0; n_b = '0; n_mode = 0;

    #1;
    check("reset_out_valid", {31'd0, m_out_valid}, 32'd0);
    check("reset_z", {28'd0, m_z}, 32'd0);
    check("reset_in_ready", {31'd0, m_in_ready}, 32'd1);
    #20;
    @(negedge clk);
    nreset = 1'b1;

    // single beats, 2-cycle latency, then the output goes idle again
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      m_a = vecs[i].a; m_b = vecs[i].b; m_mode = vecs[i].mode; m_in_valid = 1;
      #1 check($sformatf("vec%0d_in_ready", i), {31'd0, m_in_ready}, 32'd1);
      @(negedge clk);
      m_in_valid = 0;
      #1 check($sformatf("vec%0d_early", i), {31'd0, m_out_valid}, 32'd0);
      @(negedge clk);
      #1 check($sformatf("vec%0d_valid", i), {31'd0, m_out_valid}, 32'd1);
      check($sformatf("vec%0d_z", i), {28'd0, m_z}, {28'd0, vecs[i].exp_z});
      @(negedge clk);
      #1 check($sformatf("vec%0d_idle", i), {31'd0, m_out_valid}, 32'd0);
    end

    // backpressure: capacity two, z held, release drains in order
    @(negedge clk);
    m_out_ready = 0;
    m_a = vecs[0].a; m_b = vecs[0].b; m_mode = vecs[0].mode; m_in_valid = 1;
    #1 check("bp_beat0_ready", {31'd0, m_in_ready}, 32'd1);
    @(negedge clk);
    m_a = vecs[1].a; m_b = vecs[1].b; m_mode = vecs[1].mode;
    #1 check("bp_beat1_ready", {31'd0, m_in_ready}, 32'd1);
    @(negedge clk);
    m_a = vecs[2].a; m_b = vecs[2].b; m_mode = vecs[2].mode;
    #1 check("bp_beat2_blocked", {31'd0, m_in_ready}, 32'd0);
    check("bp_valid", {31'd0, m_out_valid}, 32'd1);
    check("bp_z0", {28'd0, m_z}, 32'hC);
    @(negedge clk);
    #1 check("bp_still_blocked", {31'd0, m_in_ready}, 32'd0);
    check("bp_z_held", {28'd0, m_z}, 32'hC);
    m_out_ready = 1;
    #1 check("bp_release_ready", {31'd0, m_in_ready}, 32'd1);
    @(negedge clk);
    m_in_valid = 0;
    #1 check("bp_out1_valid", {31'd0, m_out_valid}, 32'd1);
    check("bp_out1_z", {28'd0, m_z}, 32'h3);
    @(negedge clk);
    #1 check("bp_out2_valid", {31'd0, m_out_valid}, 32'd1);
    check("bp_out2_z", {28'd0, m_z}, 32'h4);
    @(negedge clk);
    #1 check("bp_empty", {31'd0, m_out_valid}, 32'd0);

    // asynchronous reset with two beats in flight
    @(negedge clk);
    m_out_ready = 0;
    m_a = vecs[3].a; m_b = vecs[3].b; m_mode = 1; m_in_valid = 1;
    @(negedge clk);
    m_a = vecs[4].a; m_b = vecs[4].b; m_mode = 1;
    @(negedge clk);
    m_in_valid = 0;
    #1 check("rst_inflight_valid", {31'd0, m_out_valid}, 32'd1);
    #2 nreset = 1'b0;
    #1 check("rst_async_valid", {31'd0, m_out_valid}, 32'd0);
    check("rst_async_z", {28'd0, m_z}, 32'd0);
    check("rst_async_in_ready", {31'd0, m_in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    m_out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 check($sformatf("rst_no_stale%0d", c), {31'd0, m_out_valid}, 32'd0);
      check($sformatf("rst_ready%0d", c), {31'd0, m_in_ready}, 32'd1);
    end

    // continuous streaming: 16 beats, results on 16 consecutive cycles
    q.delete();
    got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c < 16) begin
        m_a = 12'($urandom); m_b = 8'($urandom); m_mode = 1'($urandom); m_in_valid = 1;
      end else begin
        m_in_valid = 0;
      end
      #1;
      if (c >= 2 && c < 18) check($sformatf("stream_valid_c%0d", c), {31'd0, m_out_valid}, 32'd1);
      if (m_out_valid && m_out_ready) begin
        if (q.size() > 0) begin
          exp4 = q.pop_front();
          check($sformatf("stream_z%0d", got), {28'd0, m_z}, {28'd0, exp4});
        end else begin
          check("stream_extra_beat", 32'd1, 32'd0);
        end
        got++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (m_in_valid) begin
        check($sformatf("stream_in_ready_c%0d", c), {31'd0, m_in_ready}, 32'd1);
        if (m_in_ready) q.push_back(ref_main(m_a, m_b, m_mode));
      end
    end
    check("stream_count", got, 32'd16);
    check("stream_first_cycle", first_c, 32'd2);
    check("stream_span", last_c - first_c, 32'd15);

    // W=1, STAGES=1: exhaustive over a0,a1,a2,b0,b1 in AOI mode, back to back
    exp_prev = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      #1;
      if (k > 0) begin
        check($sformatf("sweep%0d_valid", k - 1), {31'd0, s_out_valid}, 32'd1);
        check($sformatf("sweep%0d_z", k - 1), {31'd0, s_z}, {31'd0, exp_prev});
      end
      if (k < 32) begin
        s_a = k[2:0]; s_b = k[4:3]; s_mode = 0; s_in_valid = 1;
        exp_prev = ~((k[0] & k[1] & k[2]) | k[3] | k[4]);
      end else begin
        s_in_valid = 0;
      end
    end
    @(negedge clk);
    #1 check("sweep_idle", {31'd0, s_out_valid}, 32'd0);

    // NO=0, STAGES=4: latency of a lone beat, b must be ignored
    @(negedge clk);
    n_a = 12'h7F3; n_b = 4'hF; n_mode = 1; n_in_valid = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_in_valid = 0;
      #1 check($sformatf("noor_lat_c%0d", c), {31'd0, n_out_valid}, (c == 4) ? 32'd1 : 32'd0);
    end
    check("noor_lat_z", {28'd0, n_z}, 32'h3);
    @(negedge clk);
    #1 check("noor_lat_idle", {31'd0, n_out_valid}, 32'd0);

    // NO=0, STAGES=4: random valid/ready, strict ordering
    q.delete();
    sent = 0; rcv = 0;
    for (int c = 0; c < 300 && rcv < 12; c++) begin
      @(negedge clk);
      n_in_valid  = (sent < 12) && ($urandom_range(0, 1) == 1);
      n_a         = 12'($urandom);
      n_b         = 4'($urandom);
      n_mode      = 1'($urandom);
      n_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (n_out_valid && n_out_ready) begin
        if (q.size() > 0) begin
          exp4 = q.pop_front();
          check($sformatf("noor_z%0d", rcv), {28'd0, n_z}, {28'd0, exp4});
        end else begin
          check("noor_extra_beat", 32'd1, 32'd0);
        end
        rcv++;
      end
      if (n_in_valid && n_in_ready) begin
        q.push_back(ref_noor(n_a, n_mode));
        sent++;
      end
    end
    @(negedge clk);
    n_in_valid = 0;
    n_out_ready = 1;
    check("noor_received", rcv, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
